// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR sequencer: state encodings, field widths, defaults.
package fir_ctrl_pkg;

  localparam int unsigned BAND_W         = 16;
  localparam int unsigned FSEL_W         = 2;
  localparam int unsigned STATE_W        = 3;
  localparam int unsigned DEF_PIPE_LAT   = 4;
  localparam int unsigned DEF_COE_CYCLES = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_COE = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Configuration handshake between the bus and the FIR sequencer.
interface fir_seq_ctrl_if;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [fir_ctrl_pkg::BAND_W-1:0] cfg_bandlow;
  logic [fir_ctrl_pkg::BAND_W-1:0] cfg_bandhi;
  logic [fir_ctrl_pkg::FSEL_W-1:0] cfg_filter_select;

  modport master (output cfg_valid, cfg_bandlow, cfg_bandhi, cfg_filter_select,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_bandlow, cfg_bandhi, cfg_filter_select,
                  output cfg_ready);
endinterface

// File: rtl/fir_valid_pipe.sv
// Valid-bit shift register tracking samples in flight through the FIR.
module fir_valid_pipe #(
  parameter int unsigned DEPTH = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic any
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage pipe: just a flop.
      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= din;
      end
    end else begin : g_many
      // Shift toward the output end every cycle.
      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];
  assign any  = |sr;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the FIR datapath: config load, coefficient wait, gated sample flow, drain.
module fir_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = DEF_PIPE_LAT,
  parameter int unsigned COE_CYCLES = DEF_COE_CYCLES,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               CLK,
  input  logic               reset,
  fir_seq_ctrl_if.slave      cfg,
  output logic [BAND_W-1:0]  bandlow,
  output logic [BAND_W-1:0]  bandhi,
  output logic [FSEL_W-1:0]  filter_select,
  output logic               start_coe,
  input  logic               run_en,
  input  logic               in_empty,
  input  logic               out_afull,
  output logic               req_get,
  output logic               hold,
  output logic               wr_out,
  output logic               busy,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   sample_cnt
);

  localparam int unsigned      COE_W    = $clog2(COE_CYCLES);
  localparam logic [COE_W-1:0] COE_LOAD = COE_W'(COE_CYCLES - 1);

  state_t           cur_st, nxt_st;
  logic [COE_W-1:0] coe_cnt;
  logic             pipe_any;
  logic             latch_cfg;
  logic             ready_c;

  fir_valid_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
    .CLK   (CLK),
    .reset (reset),
    .din   (req_get),
    .dout  (wr_out),
    .any   (pipe_any)
  );

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cur_st <= ST_IDLE;
    else        cur_st <= nxt_st;
  end

  // Next-state and strobe decode.
  always_comb begin
    nxt_st    = cur_st;
    start_coe = 1'b0;
    req_get   = 1'b0;
    ready_c   = 1'b0;
    latch_cfg = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (cfg.cfg_valid) begin
          latch_cfg = 1'b1;
          nxt_st    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        start_coe = 1'b1;
        nxt_st    = ST_WAIT_COE;
      end
      ST_WAIT_COE: begin
        if (coe_cnt == '0) nxt_st = ST_RUN;
      end
      ST_RUN: begin
        req_get = run_en & ~in_empty & ~out_afull & ~cfg.cfg_valid;
        if (cfg.cfg_valid) nxt_st = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_any) begin
          ready_c = 1'b1;
          if (cfg.cfg_valid) begin
            latch_cfg = 1'b1;
            nxt_st    = ST_LOAD;
          end else begin
            nxt_st = ST_RUN;
          end
        end else if (!cfg.cfg_valid) begin
          nxt_st = ST_RUN;
        end
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted even though IDLE would offer it.
  assign cfg.cfg_ready = reset & ready_c;
  assign hold          = ~req_get;
  assign state         = cur_st;
  assign busy          = ((cur_st != ST_IDLE) && (cur_st != ST_RUN)) | pipe_any;

  // Configuration registers driven to the FIR.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bandlow       <= '0;
      bandhi        <= '0;
      filter_select <= '0;
    end else if (latch_cfg) begin
      bandlow       <= cfg.cfg_bandlow;
      bandhi        <= cfg.cfg_bandhi;
      filter_select <= cfg.cfg_filter_select;
    end
  end

  // Coefficient-generation countdown.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                                    coe_cnt <= '0;
    else if (cur_st == ST_LOAD)                    coe_cnt <= COE_LOAD;
    else if (cur_st == ST_WAIT_COE && coe_cnt != '0) coe_cnt <= coe_cnt - COE_W'(1);
  end

  // Saturating count of samples written out since the last load.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                          sample_cnt <= '0;
    else if (cur_st == ST_LOAD)          sample_cnt <= '0;
    else if (wr_out && sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl against a cycle-timestamp reference model.
module tb_fir_seq_ctrl;

  localparam int PL    = 4;
  localparam int COE   = 32;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   bandlow, bandhi;
  logic [1:0]    filter_select;
  logic          start_coe, run_en, in_empty, out_afull;
  logic          req_get, hold, wr_out, busy;
  logic [2:0]    state;
  logic [CW-1:0] sample_cnt;

  fir_seq_ctrl_if cfg_bus ();

  fir_seq_ctrl #(.PIPE_LAT(PL), .COE_CYCLES(COE), .CNT_W(CW)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .cfg           (cfg_bus),
    .bandlow       (bandlow),
    .bandhi        (bandhi),
    .filter_select (filter_select),
    .start_coe     (start_coe),
    .run_en        (run_en),
    .in_empty      (in_empty),
    .out_afull     (out_afull),
    .req_get       (req_get),
    .hold          (hold),
    .wr_out        (wr_out),
    .busy          (busy),
    .state         (state),
    .sample_cnt    (sample_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: cycle of last accepted config, drain flag, list of pop cycles.
  int          cyc = 0;
  int          acc = -1000;
  bit          m_idle = 1'b1;
  bit          m_drain = 1'b0;
  int          pops[$];
  int          m_cnt = 0;
  logic [15:0] m_bl = '0, m_bh = '0;
  logic [1:0]  m_fs = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int n_wr     = 0;
  bit last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs #1 after the inputs settle, then advance the model.
  task automatic tick();
    bit pipe_nz, wr_exp, e_rdy, e_req, e_coe, e_busy;
    int e_state;
    #1;
    if (!reset) begin
      m_idle = 1'b1; m_drain = 1'b0; pops.delete(); m_cnt = 0;
      m_bl = '0; m_bh = '0; m_fs = '0; acc = -1000;
    end
    pipe_nz = 1'b0; wr_exp = 1'b0;
    foreach (pops[i]) begin
      if (pops[i] >= cyc - PL && pops[i] <= cyc - 1) pipe_nz = 1'b1;
      if (pops[i] == cyc - PL) wr_exp = 1'b1;
    end
    if (m_idle)                  e_state = 0;
    else if (cyc == acc + 1)     e_state = 1;
    else if (cyc < acc + 2 + COE) e_state = 2;
    else                         e_state = m_drain ? 4 : 3;
    e_rdy  = reset && ((e_state == 0) || (e_state == 4 && !pipe_nz));
    e_coe  = (e_state == 1);
    e_req  = (e_state == 3) && run_en && !in_empty && !out_afull && !cfg_bus.cfg_valid;
    e_busy = !(e_state == 0 || e_state == 3) || pipe_nz;

    chk("state",         state,             e_state);
    chk("cfg_ready",     cfg_bus.cfg_ready, e_rdy);
    chk("start_coe",     start_coe,         e_coe);
    chk("req_get",       req_get,           e_req);
    chk("hold",          hold,              !e_req);
    chk("wr_out",        wr_out,            wr_exp);
    chk("busy",          busy,              e_busy);
    chk("sample_cnt",    sample_cnt,        m_cnt);
    chk("bandlow",       bandlow,           m_bl);
    chk("bandhi",        bandhi,            m_bh);
    chk("filter_select", filter_select,     m_fs);

    if (req_get) n_req++;
    if (wr_out)  n_wr++;
    last_acc = e_rdy && cfg_bus.cfg_valid;

    if (reset) begin
      if (e_req) pops.push_back(cyc);
      if (wr_exp && m_cnt < CMAX) m_cnt++;
      if (e_coe) m_cnt = 0;
      if (e_rdy && cfg_bus.cfg_valid) begin
        m_bl = cfg_bus.cfg_bandlow; m_bh = cfg_bus.cfg_bandhi; m_fs = cfg_bus.cfg_filter_select;
        acc = cyc; m_idle = 1'b0; m_drain = 1'b0;
      end else if (e_state == 3 && cfg_bus.cfg_valid) begin
        m_drain = 1'b1;
      end else if (e_state == 4 && !cfg_bus.cfg_valid) begin
        m_drain = 1'b0;
      end
      while (pops.size() > 0 && pops[0] < cyc - PL) void'(pops.pop_front());
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic offer_cfg();
    cfg_bus.cfg_valid         = 1'b1;
    cfg_bus.cfg_bandlow       = 16'($urandom);
    cfg_bus.cfg_bandhi        = 16'($urandom);
    cfg_bus.cfg_filter_select = 2'($urandom);
  endtask

  initial begin
    bit got;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_bandlow = '0;
    cfg_bus.cfg_bandhi = '0;  cfg_bus.cfg_filter_select = '0;
    run_en = 1'b0; in_empty = 1'b1; out_afull = 1'b0;
    #1 reset = 1'b0;
    @(negedge CLK);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Power-on config: latched next cycle, start_coe one cycle, RUN at T+2+COE.
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_bandlow = 16'h0100;
    cfg_bus.cfg_bandhi = 16'h0800; cfg_bus.cfg_filter_select = 2'd2;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    tick();
    chk("poweron_bandlow", bandlow, 16'h0100);
    repeat (32) tick();
    #1 chk("run_at_T34", state, 3);

    // Streaming 10 samples.
    run_en = 1'b1; in_empty = 1'b0; n_req = 0; n_wr = 0;
    repeat (10) tick();
    in_empty = 1'b1;
    repeat (6) tick();
    chk("stream_req", n_req, 10);
    chk("stream_wr",  n_wr, 10);
    chk("stream_cnt", sample_cnt, 10);

    // Backpressure mid-stream.
    in_empty = 1'b0; n_wr = 0;
    repeat (3) tick();
    out_afull = 1'b1; n_req = 0;
    repeat (5) tick();
    chk("afull_no_pop", n_req, 0);
    out_afull = 1'b0;
    repeat (3) tick();
    in_empty = 1'b1;
    repeat (6) tick();
    chk("afull_wr", n_wr, 6);

    // Reconfigure with 3 samples in flight.
    in_empty = 1'b0;
    repeat (3) tick();
    offer_cfg();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = last_acc;
    end
    chk("reconfig_accept", got, 1);
    cfg_bus.cfg_valid = 1'b0;
    repeat (34) tick();

    // Saturation of the sample counter.
    in_empty = 1'b0;
    repeat (40) tick();
    in_empty = 1'b1;
    repeat (6) tick();
    chk("cnt_saturate", sample_cnt, CMAX);

    // Randomized traffic and reconfiguration.
    for (int i = 0; i < 600; i++) begin
      run_en    = ($urandom_range(0, 3) != 0);
      in_empty  = ($urandom_range(0, 3) == 0);
      out_afull = ($urandom_range(0, 4) == 0);
      if (last_acc)                                          cfg_bus.cfg_valid = 1'b0;
      else if (!cfg_bus.cfg_valid && $urandom_range(0, 39) == 0) offer_cfg();
      else if (cfg_bus.cfg_valid && $urandom_range(0, 5) == 0)   cfg_bus.cfg_valid = 1'b0;
      tick();
    end

    // Reset mid-run with 2 samples in flight.
    cfg_bus.cfg_valid = 1'b0; run_en = 1'b0; out_afull = 1'b0;
    repeat (40) tick();
    run_en = 1'b1; in_empty = 1'b0;
    repeat (2) tick();
    reset = 1'b0; in_empty = 1'b1;
    tick();
    chk("rst_state", state, 0);
    tick();
    reset = 1'b1; n_wr = 0;
    repeat (10) tick();
    chk("rst_no_wr", n_wr, 0);

    // Idle RUN with an empty input FIFO.
    offer_cfg();
    tick();
    cfg_bus.cfg_valid = 1'b0;
    repeat (33) tick();
    n_req = 0; n_wr = 0;
    repeat (20) tick();
    chk("empty_no_req", n_req, 0);
    chk("empty_no_wr",  n_wr, 0);
    chk("empty_busy",   busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Single-clock sequencer for the FIR filter datapath and its input/output FIFOs.
- Accepts filter configuration (band limits, filter type) from the bus and pulses coefficient generation.
- Gates sample pops from the input FIFO so the output FIFO can never overflow.
- On a reconfiguration request, drains in-flight samples before reloading coefficients.

Parameters:
- PIPE_LAT, 4, FIR latency in cycles from the req_get pop to a valid sample on the FIR output (≥1).
- COE_CYCLES, 32, cycles allowed for coefficient generation after the start_coe pulse (≥2).
- CNT_W, 16, width of the output sample counter.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  configuration accepted this cycle when cfg_valid is also high.
- cfg_bandlow  in  16  requested low band edge.
- cfg_bandhi  in  16  requested high band edge.
- cfg_filter_select  in  2  requested filter type.
- bandlow  out  16  registered band edge driven to the FIR.
- bandhi  out  16  registered band edge driven to the FIR.
- filter_select  out  2  registered filter type driven to the FIR.
- start_coe  out  1  one-cycle coefficient-generation strobe.
- run_en  in  1  software enable for sample flow.
- in_empty  in  1  input FIFO empty.
- out_afull  in  1  output FIFO has ≤ PIPE_LAT free slots.
- req_get  out  1  pop the input FIFO / advance the FIR this cycle.
- hold  out  1  FIR hold; equals the inverse of req_get.
- wr_out  out  1  write strobe to the output FIFO (start_toread).
- busy  out  1  high whenever state is not IDLE or RUN, or in-flight samples are non-zero.
- state  out  3  encoded state for debug.
- sample_cnt  out  CNT_W  outputs written since the last configuration.

Behaviour:
- Reset (asynchronous, active-low). While reset=0, every register clears immediately:
  - state=IDLE; bandlow, bandhi, filter_select = 0.
  - start_coe, req_get, wr_out, cfg_ready, busy = 0; hold=1.
  - sample_cnt=0; valid shift register cleared.
  - Reset asserted mid-load or mid-run discards all in-flight samples; no wr_out is issued for them.
- States and encodings: IDLE=0, LOAD=1, WAIT_COE=2, RUN=3, DRAIN=4.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch cfg_* into bandlow, bandhi and filter_select (visible the next cycle) and go to LOAD.
- LOAD (one cycle):
  - start_coe=1 and the coefficient counter loads COE_CYCLES-1.
  - Go to WAIT_COE.
- WAIT_COE:
  - Counter decrements each cycle; at 0 go to RUN.
  - Clear sample_cnt on entry.
  - Cycle accounting: config accepted at cycle T means start_coe high at T+1 and the first possible req_get at T+2+COE_CYCLES.
- RUN:
  - req_get = run_en & ~in_empty & ~out_afull & ~cfg_valid (combinational from registered state and inputs).
  - cfg_ready=0.
  - If cfg_valid is high, go to DRAIN. cfg_valid has priority over a pop, so no pop occurs in the transition cycle.
- DRAIN:
  - req_get=0.
  - Stay until the valid shift register is all zero.
  - cfg_ready=1 only in the final cycle, i.e. when the shift register is zero. On cfg_valid in that cycle, latch cfg_* and go to LOAD.
  - If cfg_valid drops before then, return to RUN.
- Pipeline tracking:
  - PIPE_LAT-deep shift register; bit 0 loads req_get.
  - wr_out = last bit, so wr_out rises exactly PIPE_LAT cycles after the corresponding req_get.
  - The shift register advances every cycle in every state except during reset.
- sample_cnt increments on each wr_out and saturates at all-ones (no wrap).
- Configuration outputs never change while in RUN or while any sample is in flight.
- start_coe is never asserted while the shift register is non-zero.
- Flow-control corner cases:
  - out_afull asserted with samples in flight still lets those samples complete. Overflow is prevented by the FIFO threshold definition.
  - Input FIFO empty and output FIFO almost-full in the same cycle: no pop.
  - run_en low in RUN: no pops, in-flight samples still drain to wr_out.

Decomposition:
- Shared package fir_ctrl_pkg holds:
  - state encodings (IDLE..DRAIN);
  - band/filter width constants: 16, 2;
  - default PIPE_LAT and COE_CYCLES.
- One natural sub-module: fir_valid_pipe, a parameterised valid shift register with an any-bit-set output.
- The FSM, the coefficient counter and the sample counter stay in fir_seq_ctrl.

Test Plan:
- Power-on config: reset low then high; cfg_valid=1 with bandlow=0x0100, bandhi=0x0800, filter_select=2 at T → outputs latched at T+1; start_coe high only at T+1; state=RUN at T+2+32.
- Streaming: run_en=1, in_empty=0, out_afull=0 for 10 cycles → 10 req_get pulses; 10 wr_out pulses, each offset by exactly 4 cycles; sample_cnt=10.
- Backpressure: out_afull=1 mid-stream for 5 cycles → req_get=0 in those cycles; wr_out for samples already in flight still arrives; none lost.
- Reconfigure mid-stream: cfg_valid with 3 samples in flight → immediate req_get=0; DRAIN until the 3 wr_out complete; then cfg latched, start_coe pulses, sample_cnt cleared.
- Reset mid-run: drop reset with 2 samples in flight → all outputs at reset values within the same cycle; no wr_out afterwards; state=IDLE.
- Corner: in_empty=1 and cfg_valid=0 in RUN for 20 cycles → no req_get, no wr_out, busy=0.
